// File: rtl/debug_controller_if.sv
// rtl/debug_controller_if.sv - UART, instruction-load, datapath-control and debug-read signals of debug_controller
interface debug_controller_if #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int PROC_BITS        = 32,
    parameter int DATA_ADDRS_BITS  = 10,
    parameter int RF_REGS_LEN      = 1024
);
    logic [7:0]                  i_rx_data;
    logic                        i_rx_valid;
    logic [7:0]                  o_tx_data;
    logic                        o_tx_start;
    logic                        i_tx_busy;
    logic                        i_halt;
    logic [RF_REGS_LEN-1:0]      i_rf_regs;
    logic [PROC_BITS-1:0]        i_mem_data;
    logic                        o_dp_enable;
    logic                        o_write_inst_mem;
    logic [PC_BITS-1:0]          o_inst_mem_addr;
    logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
    logic                        o_debug_read_data;
    logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address;
    logic                        o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_halt, i_rf_regs, i_mem_data,
        output o_tx_data, o_tx_start, o_dp_enable, o_write_inst_mem, o_inst_mem_addr,
               o_inst_mem_data, o_debug_read_data, o_debug_read_address, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_busy, i_halt, i_rf_regs, i_mem_data,
        input  o_tx_data, o_tx_start, o_dp_enable, o_write_inst_mem, o_inst_mem_addr,
               o_inst_mem_data, o_debug_read_data, o_debug_read_address, o_busy
    );
endinterface

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - UART host sequencer: program load, run/step of the datapath, register/memory dump
// Optional CYCLE_COUNT_EN: appends a 32-bit count of enabled datapath cycles to every dump.
module debug_controller #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int PROC_BITS        = 32,
    parameter int DATA_ADDRS_BITS  = 10,
    parameter int RF_REGS_LEN      = 1024,
    parameter int DUMP_WORDS       = 16
) (
    input logic               clk,
    input logic               rst,
    debug_controller_if.master bus
);
    localparam int IDX_BITS = (DATA_ADDRS_BITS > 5) ? DATA_ADDRS_BITS : 5;

    typedef enum logic [3:0] {
        IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, SEND_ACK, RUN, STEP, DUMP_RF, DUMP_MEM, DUMP_CNT
    } state_t;
    typedef enum logic [1:0] {TX_FREE, TX_SETTLE, TX_DRAIN} tx_phase_t;
    typedef enum logic [1:0] {W_FETCH, W_REQ, W_LATCH, W_SEND} word_phase_t;

    state_t                      state;
    tx_phase_t                   tx_phase;
    word_phase_t                 word_phase;
    logic [7:0]                  word_cnt;
    logic [1:0]                  byte_idx;
    logic [IDX_BITS-1:0]         word_idx;
    logic [INSTRUCTION_BITS-1:0] load_shift;
    logic [31:0]                 tx_word;
    logic [PROC_BITS-1:0]        rf_word;
    logic                        tx_ready;
`ifdef CYCLE_COUNT_EN
    logic [31:0]                 cycle_cnt;
`endif

    assign rf_word  = bus.i_rf_regs[PROC_BITS*int'(word_idx[4:0]) +: PROC_BITS];
    // A new byte may start only after the previous start has been seen and busy has dropped again.
    assign tx_ready = (tx_phase == TX_FREE) && !bus.i_tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= IDLE;
            tx_phase                 <= TX_FREE;
            word_phase               <= W_FETCH;
            word_cnt                 <= '0;
            byte_idx                 <= '0;
            word_idx                 <= '0;
            load_shift               <= '0;
            tx_word                  <= '0;
            bus.o_tx_data            <= '0;
            bus.o_tx_start           <= 1'b0;
            bus.o_dp_enable          <= 1'b0;
            bus.o_write_inst_mem     <= 1'b0;
            bus.o_inst_mem_addr      <= '0;
            bus.o_inst_mem_data      <= '0;
            bus.o_debug_read_data    <= 1'b0;
            bus.o_debug_read_address <= '0;
            bus.o_busy               <= 1'b0;
`ifdef CYCLE_COUNT_EN
            cycle_cnt                <= '0;
`endif
        end else begin
            bus.o_tx_start        <= 1'b0;
            bus.o_debug_read_data <= 1'b0;
            if (bus.o_write_inst_mem) begin
                bus.o_write_inst_mem <= 1'b0;
                bus.o_inst_mem_addr  <= bus.o_inst_mem_addr + PC_BITS'(4);
            end
            case (tx_phase)
                TX_SETTLE: tx_phase <= TX_DRAIN;
                TX_DRAIN:  if (!bus.i_tx_busy) tx_phase <= TX_FREE;
                default:   ;
            endcase
`ifdef CYCLE_COUNT_EN
            if (bus.o_dp_enable) cycle_cnt <= cycle_cnt + 32'd1;
`endif
            case (state)
                IDLE: if (bus.i_rx_valid) begin
                    case (bus.i_rx_data)
                        8'h4C: begin
                            state      <= LOAD_CNT;
                            bus.o_busy <= 1'b1;
`ifdef CYCLE_COUNT_EN
                            cycle_cnt  <= '0;
`endif
                        end
                        8'h52: begin
                            state           <= RUN;
                            bus.o_busy      <= 1'b1;
                            bus.o_dp_enable <= !bus.i_halt;
                        end
                        8'h53: begin
                            state           <= STEP;
                            bus.o_busy      <= 1'b1;
                            bus.o_dp_enable <= !bus.i_halt;
                        end
                        default: ;
                    endcase
                end
                LOAD_CNT: if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == 8'h00) begin
                        state      <= IDLE;
                        bus.o_busy <= 1'b0;
                    end else begin
                        word_cnt            <= bus.i_rx_data;
                        bus.o_inst_mem_addr <= '0;
                        byte_idx            <= '0;
                        state               <= LOAD_BYTE;
                    end
                end
                LOAD_BYTE: if (bus.i_rx_valid) begin
                    load_shift <= {load_shift[INSTRUCTION_BITS-9:0], bus.i_rx_data};
                    byte_idx   <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state <= LOAD_WRITE;
                end
                LOAD_WRITE: begin
                    bus.o_write_inst_mem <= 1'b1;
                    bus.o_inst_mem_data  <= load_shift;
                    word_cnt             <= word_cnt - 8'd1;
                    state                <= (word_cnt == 8'd1) ? SEND_ACK : LOAD_BYTE;
                end
                SEND_ACK: if (tx_ready) begin
                    bus.o_tx_start <= 1'b1;
                    bus.o_tx_data  <= 8'hAA;
                    tx_phase       <= TX_SETTLE;
                    state          <= IDLE;
                    bus.o_busy     <= 1'b0;
                end
                RUN, STEP: begin
                    if (state == STEP || bus.i_halt) begin
                        bus.o_dp_enable <= 1'b0;
                        state           <= DUMP_RF;
                        word_idx        <= '0;
                        byte_idx        <= '0;
                        word_phase      <= W_FETCH;
                    end else begin
                        bus.o_dp_enable <= 1'b1;
                    end
                end
                DUMP_RF, DUMP_MEM, DUMP_CNT: begin
                    case (word_phase)
                        W_FETCH: begin
                            if (state == DUMP_MEM) begin
                                bus.o_debug_read_data    <= 1'b1;
                                bus.o_debug_read_address <= word_idx[DATA_ADDRS_BITS-1:0];
                                word_phase               <= W_REQ;
                            end else begin
                                word_phase <= W_SEND;
                                if (state == DUMP_RF) tx_word <= 32'(rf_word);
`ifdef CYCLE_COUNT_EN
                                else tx_word <= cycle_cnt;
`endif
                            end
                        end
                        W_REQ: word_phase <= W_LATCH;
                        // Read data is valid exactly one cycle after the request was presented.
                        W_LATCH: begin
                            tx_word    <= 32'(bus.i_mem_data);
                            word_phase <= W_SEND;
                        end
                        W_SEND: if (tx_ready) begin
                            bus.o_tx_start <= 1'b1;
                            bus.o_tx_data  <= tx_word[31:24];
                            tx_word        <= {tx_word[23:0], 8'h00};
                            tx_phase       <= TX_SETTLE;
                            byte_idx       <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                word_phase <= W_FETCH;
                                word_idx   <= word_idx + IDX_BITS'(1);
                                if (state == DUMP_RF && word_idx == IDX_BITS'(31)) begin
                                    state    <= DUMP_MEM;
                                    word_idx <= '0;
                                end else if (state == DUMP_MEM && word_idx == IDX_BITS'(DUMP_WORDS - 1)) begin
                                    word_idx <= '0;
`ifdef CYCLE_COUNT_EN
                                    state    <= DUMP_CNT;
`else
                                    state      <= IDLE;
                                    bus.o_busy <= 1'b0;
`endif
                                end else if (state == DUMP_CNT) begin
                                    word_idx   <= '0;
                                    state      <= IDLE;
                                    bus.o_busy <= 1'b0;
                                end
                            end
                        end
                        default: word_phase <= W_FETCH;
                    endcase
                end
                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - scoreboard bench for debug_controller (load, run, step, dump, backpressure, reset)
`timescale 1ns/1ps
module tb_debug_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_controller_if dbg ();
    debug_controller dut (.clk(clk), .rst(rst), .bus(dbg));

    int checks = 0;
    int passes = 0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] exp_cyc = 0;
    int tx_hold = 2;
    int busy_cnt = 0;
    int start_while_busy = 0;
    int data_changes = 0;
    int en_cycles = 0;
    int wr_count = 0;
    int tx_count = 0;
    logic [7:0] held_data = 0;
    logic       mem_req_seen = 0;
    logic [9:0] mem_req_addr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rf_val(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (k == 1) return 32'h0000_0005;
        return {kb, 8'h5A, ~kb, kb ^ 8'hC3};
    endfunction

    function automatic logic [31:0] mem_val(input logic [9:0] a);
        return {8'hC0, a[7:0], 8'hDE, a[7:0] ^ 8'h55};
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump();
        for (int k = 0; k < 32; k++) push_word(rf_val(k));
        for (int a = 0; a < 16; a++) push_word(mem_val(10'(a)));
`ifdef CYCLE_COUNT_EN
        push_word(exp_cyc);
`endif
    endtask

    // Transmitter, write-port and enable monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        if (rst) begin
            dbg.i_tx_busy = 1'b0;
        end else begin
            if (dbg.o_dp_enable) en_cycles++;
            if (dbg.o_write_inst_mem) begin
                wr_count++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    $display("FAIL inst_write: unexpected write addr %0h data %0h", dbg.o_inst_mem_addr, dbg.o_inst_mem_data);
                end else begin
                    check("inst_write", {dbg.o_inst_mem_addr, dbg.o_inst_mem_data}, exp_wr.pop_front());
                end
            end
            if (dbg.i_tx_busy) begin
                if (dbg.o_tx_start) start_while_busy++;
                if (dbg.o_tx_data !== held_data) data_changes++;
                if (busy_cnt == 0) dbg.i_tx_busy = 1'b0;
                else busy_cnt--;
            end else if (dbg.o_tx_start) begin
                tx_count++;
                held_data = dbg.o_tx_data;
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL tx_byte: unexpected byte %0h", dbg.o_tx_data);
                end else begin
                    check("tx_byte", dbg.o_tx_data, exp_tx.pop_front());
                end
                dbg.i_tx_busy = 1'b1;
                busy_cnt = tx_hold;
            end
            mem_req_seen = dbg.o_debug_read_data;
            mem_req_addr = dbg.o_debug_read_address;
        end
    end

    // Debug read port: data is valid only during the cycle after the request.
    always @(posedge clk) begin
        #1;
        if (mem_req_seen) dbg.i_mem_data = mem_val(mem_req_addr);
        else dbg.i_mem_data = 32'hDEAD_BEEF;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        dbg.i_rx_data  = b;
        dbg.i_rx_valid = 1'b1;
        @(negedge clk);
        dbg.i_rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((dbg.o_busy || dbg.i_tx_busy || exp_tx.size() != 0 || exp_wr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " timeout"}, 64'(n >= budget), 64'd0);
        check({name, " tx_left"}, 64'(exp_tx.size()), 64'd0);
        check({name, " wr_left"}, 64'(exp_wr.size()), 64'd0);
        check({name, " enable_off"}, dbg.o_dp_enable, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, dbg.o_busy, 1'b0);
        check({tag, " dp_enable"}, dbg.o_dp_enable, 1'b0);
        check({tag, " tx_start"}, dbg.o_tx_start, 1'b0);
        check({tag, " tx_data"}, dbg.o_tx_data, 8'h00);
        check({tag, " write"}, dbg.o_write_inst_mem, 1'b0);
        check({tag, " inst_addr"}, dbg.o_inst_mem_addr, 32'h0);
        check({tag, " inst_data"}, dbg.o_inst_mem_data, 32'h0);
        check({tag, " read_req"}, dbg.o_debug_read_data, 1'b0);
        check({tag, " read_addr"}, dbg.o_debug_read_address, 10'h0);
    endtask

    initial begin
        int wr0, tx0;
        rst            = 1'b1;
        dbg.i_rx_data  = 8'h00;
        dbg.i_rx_valid = 1'b0;
        dbg.i_halt     = 1'b0;
        for (int k = 0; k < 32; k++) dbg.i_rf_regs[32*k +: 32] = rf_val(k);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Two-word load followed by a single 0xAA acknowledge.
        wr0 = wr_count; tx0 = tx_count;
        exp_wr.push_back({32'h0, 32'h2001_0005});
        exp_wr.push_back({32'h4, 32'hFC00_0000});
        exp_tx.push_back(8'hAA);
        exp_cyc = 0;
        send(8'h4C); send(8'h02);
        send(8'h20); send(8'h01); send(8'h00); send(8'h05);
        send(8'hFC); send(8'h00); send(8'h00); send(8'h00);
        wait_done("load", 2000);
        check("load writes", 64'(wr_count - wr0), 64'd2);
        check("load tx", 64'(tx_count - tx0), 64'd1);
        check("load busy", dbg.o_busy, 1'b0);

        // Zero-length load, then an unknown command byte.
        wr0 = wr_count; tx0 = tx_count;
        exp_cyc = 0;
        send(8'h4C); send(8'h00);
        repeat (4) @(negedge clk);
        check("zero_load busy", dbg.o_busy, 1'b0);
        send(8'h7F);
        check("unknown busy", dbg.o_busy, 1'b0);
        repeat (4) @(negedge clk);
        check("unknown busy later", dbg.o_busy, 1'b0);
        check("zero_load writes", 64'(wr_count - wr0), 64'd0);
        check("zero_load tx", 64'(tx_count - tx0), 64'd0);

        // Run until halt is raised after 10 enabled cycles, then the full dump.
        tx0 = tx_count;
        en_cycles = 0;
        exp_cyc = exp_cyc + 10;
        push_dump();
        send(8'h52);
        repeat (8) @(negedge clk);
        dbg.i_halt = 1'b1;
        wait_done("run", 5000);
        check("run enable cycles", 64'(en_cycles), 64'd10);
`ifdef CYCLE_COUNT_EN
        check("run dump bytes", 64'(tx_count - tx0), 64'd196);
`else
        check("run dump bytes", 64'(tx_count - tx0), 64'd192);
`endif

        // Single step with the datapath running.
        dbg.i_halt = 1'b0;
        en_cycles = 0;
        exp_cyc = exp_cyc + 1;
        push_dump();
        send(8'h53);
        wait_done("step", 5000);
        check("step enable cycles", 64'(en_cycles), 64'd1);

        // Step while halted: dump only.
        dbg.i_halt = 1'b1;
        en_cycles = 0;
        push_dump();
        send(8'h53);
        wait_done("step_halted", 5000);
        check("step_halted enable cycles", 64'(en_cycles), 64'd0);

        // Run with halt already high, under heavy transmit backpressure.
        tx_hold = 50;
        tx0 = tx_count;
        en_cycles = 0;
        push_dump();
        send(8'h52);
        wait_done("backpressure", 20000);
        check("backpressure enable cycles", 64'(en_cycles), 64'd0);
`ifdef CYCLE_COUNT_EN
        check("backpressure bytes", 64'(tx_count - tx0), 64'd196);
`else
        check("backpressure bytes", 64'(tx_count - tx0), 64'd192);
`endif
        tx_hold = 2;
        dbg.i_halt = 1'b0;

        // Reset after the second byte of the first word, then a fresh load from address 0.
        send(8'h4C); send(8'h02); send(8'h11); send(8'h22);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_load_reset");
        exp_wr.push_back({32'h0, 32'hDEAD_BEEF});
        exp_tx.push_back(8'hAA);
        exp_cyc = 0;
        send(8'h4C); send(8'h01);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        wait_done("reload", 2000);

        check("start while busy", 64'(start_while_busy), 64'd0);
        check("tx data unstable", 64'(data_changes), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Host-side sequencer for the pipelined MIPS Datapath.
- Takes a byte command stream from the UART receiver and loads programs into instruction memory through the Datapath's instruction-write port.
- Runs the Datapath continuously or one clock at a time by driving its enable.
- After a run or step, sends a dump back through the UART transmitter: the register file, then a window of data memory read over the debug read port.

Parameters:
PC_BITS, 32, instruction-memory address width (byte address, word-aligned)
INSTRUCTION_BITS, 32, instruction word width
PROC_BITS, 32, data word width
DATA_ADDRS_BITS, 10, data-memory debug address width
RF_REGS_LEN, 1024, flattened register file width (32 regs x PROC_BITS)
DUMP_WORDS, 16, data-memory words sent per dump, starting at address 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid
o_tx_data  out  8  byte to transmit
o_tx_start  out  1  one-cycle transmit request
i_tx_busy  in  1  transmitter busy
i_halt  in  1  Datapath has retired HALT (level)
i_rf_regs  in  RF_REGS_LEN  register k occupies bits [PROC_BITS*k +: PROC_BITS]
i_mem_data  in  PROC_BITS  debug read data, valid the cycle after a request
o_dp_enable  out  1  Datapath enable
o_write_inst_mem  out  1  instruction-memory write strobe
o_inst_mem_addr  out  PC_BITS  instruction-memory write address
o_inst_mem_data  out  INSTRUCTION_BITS  instruction-memory write data
o_debug_read_data  out  1  debug read request
o_debug_read_address  out  DATA_ADDRS_BITS  debug read address
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, and all counters and address registers clear. Reset mid-load abandons the load; words already written stay in memory.
- All outputs are registered.
- IDLE, on i_rx_valid:
  - 0x4C 'L' -> LOAD_CNT.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - Any other byte is ignored.
- Outside IDLE, LOAD_CNT and LOAD_BYTE, i_rx_valid is ignored.
- LOAD_CNT: next byte is N, the word count.
  - N=0 -> back to IDLE, no writes, no ack.
  - Otherwise the write address is cleared to 0 -> LOAD_BYTE.
- LOAD_BYTE: collects 4 bytes MSB-first into a shift register, then goes to LOAD_WRITE.
- LOAD_WRITE:
  - Pulses o_write_inst_mem for exactly 1 cycle with the current address and data.
  - Address increments by 4 after the write.
  - Remaining word count decrements; if >0 -> LOAD_BYTE, else -> SEND_ACK.
- SEND_ACK: transmits 0xAA once, then goes to IDLE.
- RUN:
  - o_dp_enable=1 from the cycle after 'R' is accepted.
  - The first cycle i_halt=1 is sampled, o_dp_enable is 0 on the next cycle -> DUMP_RF.
  - If i_halt is already 1 on entry, enable never asserts.
- STEP:
  - If i_halt=0, o_dp_enable=1 for exactly 1 cycle.
  - If i_halt=1, no pulse.
  - Either way -> DUMP_RF.
- DUMP_RF: sends 32 regs x 4 bytes = 128 bytes, reg 0 first, MSB first.
- DUMP_MEM: for addr = 0..DUMP_WORDS-1:
  - Assert o_debug_read_data=1 with o_debug_read_address=addr for 1 cycle.
  - Latch i_mem_data the next cycle.
  - Send its 4 bytes MSB-first.
  - After the last word -> IDLE.
- TX handshake:
  - o_tx_start pulses 1 cycle, only when i_tx_busy=0.
  - The controller waits 1 cycle after each start (busy rises then), then waits for i_tx_busy=0 before the next byte.
  - o_tx_data is held stable from start until busy falls.
- Counter widths: the word counter is 8 bits. o_inst_mem_addr wraps modulo 2^PC_BITS (unreachable with N<=255).

Optional Feature:
CYCLE_COUNT_EN:
- Defined: a 32-bit counter increments every cycle o_dp_enable=1 and clears on reset and on every accepted 'L'. Its 4 bytes, MSB-first, are sent after the DUMP_MEM bytes, giving 128+4*DUMP_WORDS+4 bytes total.
- Undefined: no counter; dump is 128+4*DUMP_WORDS bytes.

Test Plan:
- Load: 'L', N=2, bytes 20 01 00 05 / FC 00 00 00 -> two write strobes, (addr 0, 0x20010005) then (addr 4, 0xFC000000); then exactly one 0xAA transmitted; o_busy back to 0.
- Zero-length load and unknown byte: 'L', 0x00 -> no write strobe, no TX, IDLE. Byte 0x7F in IDLE -> ignored, o_busy stays 0.
- Run: 'R' with i_halt raised after 10 cycles -> o_dp_enable high exactly 10 cycles. Then 128+64 bytes transmitted with DUMP_WORDS=16; reg 1 = 0x00000005 appears as bytes 4..7 = 00 00 00 05. With CYCLE_COUNT_EN, 196 bytes, last four 00 00 00 0A.
- Step: 'S' with i_halt=0 -> single 1-cycle enable pulse, then full dump. 'S' with i_halt=1 -> no enable pulse, dump only.
- TX backpressure: hold i_tx_busy high 50 cycles after each start -> no o_tx_start while busy; every byte sent once, in order, with no loss.
- Reset mid-load: assert rst after the second byte of word 1 -> next cycle all outputs 0 and FSM in IDLE. A new 'L' then starts writing at address 0.
